// File: rtl/serial_word_tx.sv
// serial_word_tx: serializes 8-bit words as a start marker (1) followed by LSB-first data bits and an idle gap.
module serial_word_tx #(
  parameter int GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       x_out,
  output logic       busy,
  output logic       frame_done
);
  typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
  state_t     r_state, w_next;
  logic [7:0] r_data;
  logic [2:0] r_bit;
  logic [3:0] r_gap;
  logic       r_ready, r_x, r_busy, r_last, r_done;
  logic       w_accept;
  assign w_accept   = in_valid & r_ready;
  assign in_ready   = r_ready;
  assign x_out      = r_x;
  assign busy       = r_busy;
  assign frame_done = r_done;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  w_next = w_accept ? START : IDLE;
      START: w_next = DATA;
      DATA:  w_next = (r_bit != 3'd7) ? DATA : (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   w_next = (r_gap == GAP_LAST) ? IDLE : GAP;
    endcase
  end
  // Outputs are registered from the current state, so they trail it by one cycle;
  // ready is additionally dropped on the accept edge to stop a double accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_data  <= 8'h00;
      r_bit   <= 3'd0;
      r_gap   <= 4'd0;
      r_ready <= 1'b1;
      r_x     <= 1'b0;
      r_busy  <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_data <= in_data;
      r_bit   <= (r_state == DATA && r_bit != 3'd7) ? r_bit + 3'd1 : 3'd0;
      r_gap   <= (r_state == GAP && w_next == GAP) ? r_gap + 4'd1 : 4'd0;
      r_ready <= (r_state == IDLE) && !w_accept;
      r_x     <= (r_state == START) || (r_state == DATA && r_data[r_bit]);
      r_busy  <= r_state != IDLE;
      r_last  <= (r_state == DATA) && (r_bit == 3'd7);
      r_done  <= r_last;
    end
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: directed checks of serial_word_tx framing, timing, reset abort and back-to-back flow.
module tb_serial_word_tx;
  logic       clk = 1'b0, rst = 1'b1, v1 = 1'b0, v0 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       r1, x1, b1, f1, r0, x0, b0, f0;
  int         n_pass = 0, n_fail = 0, n_total = 0;
  logic [7:0] words [3] = '{8'h01, 8'hFF, 8'h80};
  always #5 clk = ~clk;
  serial_word_tx #(.GAP_CYCLES(1)) d1 (.clock(clk), .reset(rst), .in_valid(v1), .in_data(din),
    .in_ready(r1), .x_out(x1), .busy(b1), .frame_done(f1));
  serial_word_tx #(.GAP_CYCLES(0)) d0 (.clock(clk), .reset(rst), .in_valid(v0), .in_data(din),
    .in_ready(r0), .x_out(x0), .busy(b0), .frame_done(f0));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send1(input logic [7:0] w, input bit scramble);
    logic ex;
    din = w;
    v1  = 1'b1;
    tick;
    v1 = 1'b0;
    chk($sformatf("ready_low_after_accept_%0h", w), r1, 0);
    for (int j = 1; j <= 11; j++) begin
      if (scramble) din = 8'($urandom);
      tick;
      if (j == 1) ex = 1'b1;
      else if (j <= 9) ex = w[j-2];
      else ex = 1'b0;
      chk($sformatf("x_%0h_c%0d", w, j), x1, ex);
      chk($sformatf("busy_%0h_c%0d", w, j), b1, j <= 10);
      chk($sformatf("done_%0h_c%0d", w, j), f1, j == 10);
      chk($sformatf("ready_%0h_c%0d", w, j), r1, j == 11);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_x1", x1, 0);
    chk("rst_busy1", b1, 0);
    chk("rst_done1", f1, 0);
    chk("rst_x0", x0, 0);
    chk("rst_busy0", b0, 0);
    rst = 1'b0;
    chk("rst_ready1", r1, 1);
    chk("rst_ready0", r0, 1);
    send1(8'hA5, 1'b0);
    din = 8'h00;
    v0  = 1'b1;
    tick;
    v0 = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick;
      chk($sformatf("g0_x_c%0d", j), x0, j == 1);
      chk($sformatf("g0_busy_c%0d", j), b0, j <= 9);
      chk($sformatf("g0_done_c%0d", j), f0, j == 10);
      chk($sformatf("g0_ready_c%0d", j), r0, j == 10);
    end
    din = words[0];
    v1  = 1'b1;
    tick;
    for (int w = 0; w < 3; w++) begin
      din = (w < 2) ? words[w+1] : 8'h00;
      if (w == 2) v1 = 1'b0;
      for (int j = 1; j <= 12; j++) begin
        tick;
        if (j == 1) chk($sformatf("b2b%0d_marker", w), x1, 1);
        else if (j <= 9) chk($sformatf("b2b%0d_bit%0d", w, j - 2), x1, words[w][j-2]);
        if (j >= 10) chk($sformatf("b2b%0d_ready_c%0d", w, j), r1, (j == 11) || (j == 12 && w == 2));
        if (j == 10) chk($sformatf("b2b%0d_done", w), f1, 1);
      end
    end
    din = 8'h3C;
    v1  = 1'b1;
    tick;
    v1 = 1'b0;
    for (int j = 1; j <= 6; j++) tick;
    chk("abort_pre_x", x1, 1);
    chk("abort_pre_busy", b1, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_x", x1, 0);
    chk("abort_busy", b1, 0);
    chk("abort_done", f1, 0);
    for (int j = 0; j < 3; j++) begin
      tick;
      chk($sformatf("abort_nodone_%0d", j), f1, 0);
    end
    rst = 1'b0;
    chk("abort_ready", r1, 1);
    send1(8'h3C, 1'b0);
    send1(8'h96, 1'b1);
    send1(8'h5A, 1'b0);
    send1(8'h5A, 1'b0);
    send1(8'hC3, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
